msfsm_event_join: RTL and testbench
===================================

// Module: msfsm_event_join
// PURPOSE
//  Parametrised synchronous join for multi-synchronised Mealy FSM sets (N FSMs, M shared output events).
//  Each FSM raises a per-event enable. An event fires only when every owning FSM (per OWN_MASK) enables it.
//  Replaces per-design hand-written AND-merging at the top of an MSFSM set. Adds registered one-shot firing,
//  per-event handshake tracking and stall detection.
//  Sits between the fsm_mealy_behav_NN instances and the top-level output signals.
// PARAMETERS
//  N_FSM       2                   number of FSM instances joined (1..8)
//  N_EVT       9                   number of shared output events (1..64)
//  OWN_MASK    {N_FSM*N_EVT{1'b1}} bit f*N_EVT+e = 1: FSM f owns event e
//  STALL_W     8                   width of per-event stall counter
//  STALL_LIMIT 200                 PART cycles before stall flag sets (< 2**STALL_W)
// PORTS
//  clk         in   1            system clock, rising edge
//  reset       in   1            synchronous, active-high
//  en_i        in   N_FSM*N_EVT  enable from FSM f for event e at bit f*N_EVT+e
//  stall_clr_i in   1            one-cycle pulse; clears all stall_o bits
//  cnt_sel_i   in   6            event index for counter readout (EVT_COUNT_EN)
//  evt_o       out  N_EVT        one-cycle fire pulse per event, registered
//  pend_o      out  N_EVT        1 while event in PART (some but not all owners enabled)
//  stall_o     out  N_EVT        sticky stall flag per event
//  cnt_o       out  16           fire count of event cnt_sel_i
// BEHAVIOUR
//  - Clock clk. Reset is synchronous and active-high on reset.
//  - Reset: all events IDLE. evt_o, pend_o, stall_o = 0. Stall counters and fire counters = 0. Reset mid-handshake aborts it silently.
//  - Non-owner enable bits are ignored. An event with zero owners stays IDLE forever and never fires.
//  - Each event has an independent 2-bit FSM. Let all = AND of owned enables, any = OR of owned enables.
//    IDLE(0): all -> FIRE; else any -> PART; else IDLE.
//    PART(1): all -> FIRE; !any -> IDLE (withdrawal; no fire); else stay in PART, stall counter +1 saturating.
//    FIRE(2): evt_o[e] = 1 for exactly this cycle. Then !any -> IDLE, else DROP.
//    DROP(3): !any -> IDLE; else stay. Re-raised enables cannot refire until all owners have dropped (fire-once per handshake).
//  - Latency: evt_o rises 1 cycle after the edge at which all owned enables are first sampled high.
//    It stays high for 1 cycle even if enables drop in that cycle.
//  - pend_o[e] = (state==PART), registered.
//  - Stall counter clears on every exit from PART. When the count reaches STALL_LIMIT, stall_o[e] sets and stays set.
//  - stall_clr_i clears all stall_o bits. If a set and a clear coincide on the same edge, the set wins.
//  - Events are independent. Any number of events may fire on the same cycle. There is no arbitration.
//  - N_FSM=1 degenerates to a registered rising-edge one-shot per event.
// CONFIGURATION
//  EVT_COUNT_EN defined:
//    - Per-event 16-bit fire counters, +1 per FIRE cycle, saturating at 16'hFFFF.
//    - cnt_o = counter[cnt_sel_i], combinational read.
//    - cnt_sel_i >= N_EVT reads 0.
//  EVT_COUNT_EN undefined:
//    - No counters are instantiated.
//    - cnt_o is tied to 16'h0 and cnt_sel_i is unused. The ports remain.
// TESTING
//  - N_FSM=2, N_EVT=9, event 3 owned by both. FSM0 raises en at cycle 0, FSM1 at cycle 4:
//    pend_o[3]=1 cycles 1-4; evt_o[3]=1 in cycle 5 only.
//  - Both owners hold enables high for 20 cycles -> exactly one evt_o[3] pulse.
//    Drop both, re-raise both -> second pulse 1 cycle later.
//  - FSM0 raises event 2 and FSM1 never does; STALL_LIMIT=10 -> stall_o[2]=1 after 10 PART cycles.
//    FSM0 withdraws -> IDLE with no pulse. stall_clr_i -> stall_o[2]=0.
//  - Events 0, 4 and 8 fully enabled on the same edge -> evt_o = 9'h111 for one cycle.
//  - reset asserted while event 5 is in PART, then deasserted with enables still high -> pend_o=0 during reset.
//    Next cycle restarts from IDLE and fires once.
//  - EVT_COUNT_EN, 3 handshakes on event 1, cnt_sel_i=1 -> cnt_o=3.
//    cnt_sel_i=12 -> cnt_o=0. Without the macro, cnt_o=0 always.

Source files
------------

// File: rtl/msfsm_event_join_if.sv
// -----------------------------------------------------------------------------
// msfsm_event_join_if
//
// Purpose
//   Bundles the enable, control and status signals exchanged between a set of
//   multi-synchronised Mealy FSMs (plus whoever reads the joined events) and
//   the msfsm_event_join block. clk and reset are not part of the bundle.
//
// Signals
//   en_i        FSM f's enable for event e, at bit f*N_EVT+e
//   stall_clr_i one-cycle pulse that clears every sticky stall flag
//   cnt_sel_i   event index selected for fire-count readout
//   evt_o       registered one-cycle fire pulse per event
//   pend_o      registered "some but not all owners enabled" per event
//   stall_o     sticky stall flag per event
//   cnt_o       fire count of the event chosen by cnt_sel_i
//
// Modports
//   master  drives enables and controls, observes the join outputs
//   slave   the join block itself
// -----------------------------------------------------------------------------
interface msfsm_event_join_if #(
  parameter int N_FSM = 2,
  parameter int N_EVT = 9
);

  logic [N_FSM*N_EVT-1:0] en_i;
  logic                   stall_clr_i;
  logic [5:0]             cnt_sel_i;
  logic [N_EVT-1:0]       evt_o;
  logic [N_EVT-1:0]       pend_o;
  logic [N_EVT-1:0]       stall_o;
  logic [15:0]            cnt_o;

  modport master (
    output en_i,
    output stall_clr_i,
    output cnt_sel_i,
    input  evt_o,
    input  pend_o,
    input  stall_o,
    input  cnt_o
  );

  modport slave (
    input  en_i,
    input  stall_clr_i,
    input  cnt_sel_i,
    output evt_o,
    output pend_o,
    output stall_o,
    output cnt_o
  );

endinterface

// File: rtl/msfsm_event_join.sv
// -----------------------------------------------------------------------------
// msfsm_event_join
//
// Purpose
//   Synchronous join for a set of N_FSM multi-synchronised Mealy FSMs that
//   share N_EVT output events. An event fires only when every FSM that owns it
//   (OWN_MASK bit f*N_EVT+e) has its enable raised. Each event runs its own
//   small handshake FSM, so a held set of enables produces exactly one
//   registered one-cycle pulse; the owners must all drop their enables before
//   the event can fire again. Events stuck with only part of their owners
//   enabled are timed and flagged with a sticky stall bit.
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-high; aborts any handshake in flight
//   bus    msfsm_event_join_if.slave:
//            en_i, stall_clr_i, cnt_sel_i in; evt_o, pend_o, stall_o, cnt_o out
//
// Parameters
//   N_FSM       number of joined FSMs (1..8)
//   N_EVT       number of shared events (1..64)
//   OWN_MASK    ownership map, bit f*N_EVT+e set = FSM f owns event e
//   STALL_W     width of the per-event partial-enable counter
//   STALL_LIMIT partial cycles before the stall flag sets (1 .. 2**STALL_W-1)
//
// Build option
//   EVT_COUNT_EN  when defined, a saturating 16-bit fire counter per event is
//                 kept and cnt_o returns the count of event cnt_sel_i (0 for
//                 an index beyond the last event). When undefined, no
//                 counters exist and cnt_o is constant zero.
// -----------------------------------------------------------------------------
module msfsm_event_join #(
  parameter int                     N_FSM       = 2,
  parameter int                     N_EVT       = 9,
  parameter logic [N_FSM*N_EVT-1:0] OWN_MASK    = '1,
  parameter int                     STALL_W     = 8,
  parameter int                     STALL_LIMIT = 200
) (
  input  logic               clk,
  input  logic               reset,
  msfsm_event_join_if.slave  bus
);

  // Per-event handshake states.
  //   IDLE : no owner enabled
  //   PART : some, but not all, owners enabled (stall timer running)
  //   FIRE : all owners were enabled at the last edge; pulse is out now
  //   DROP : already fired this handshake, waiting for all owners to drop
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PART = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [STALL_W-1:0] STALL_MAX   = '1;
  localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);
  localparam logic [STALL_W:0]   STALL_ONE_W = (STALL_W+1)'(1);
  localparam logic [STALL_W:0]   STALL_LIM_W = (STALL_W+1)'(STALL_LIMIT);

  // Flattened views of the per-event registers, gathered from the generate
  // scopes below.
  logic [N_EVT-1:0] evt_vec;
  logic [N_EVT-1:0] pend_vec;
  logic [N_EVT-1:0] stall_vec;

  genvar gi;
  genvar gf;

  generate
    for (gi = 0; gi < N_EVT; gi++) begin : g_evt

      // Ownership and enables of this event, one bit per FSM.
      logic [N_FSM-1:0] own;
      logic [N_FSM-1:0] en_f;

      for (gf = 0; gf < N_FSM; gf++) begin : g_fsm
        assign own[gf]  = OWN_MASK[gf*N_EVT + gi];
        assign en_f[gf] = bus.en_i[gf*N_EVT + gi];
      end

      logic has_owner;
      logic all_en;
      logic any_en;

      // Non-owner bits are forced to 1 for the AND and to 0 for the OR, so
      // they have no influence. An event nobody owns would otherwise look
      // permanently "all enabled"; has_owner keeps it parked in IDLE.
      assign has_owner = |own;
      assign all_en    = has_owner & (&(en_f | ~own));
      assign any_en    = |(en_f & own);

      logic [1:0]         state_reg;
      logic [1:0]         state_next;
      logic [STALL_W-1:0] stall_cnt_reg;
      logic [STALL_W-1:0] stall_cnt_next;
      logic               evt_reg;
      logic               pend_reg;
      logic               stall_reg;
      logic               stall_next;
      logic               part_hold;
      logic               stall_hit;

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          S_IDLE: begin
            if (all_en)      state_next = S_FIRE;
            else if (any_en) state_next = S_PART;
          end
          S_PART: begin
            // Full enable wins over everything; a complete withdrawal
            // abandons the handshake without a pulse.
            if (all_en)       state_next = S_FIRE;
            else if (!any_en) state_next = S_IDLE;
          end
          S_FIRE: begin
            state_next = any_en ? S_DROP : S_IDLE;
          end
          S_DROP: begin
            // Fire-once: only a full release re-arms the event.
            if (!any_en) state_next = S_IDLE;
          end
          default: state_next = S_IDLE;
        endcase
      end

      // The stall timer counts edges on which the event remains in PART and
      // is cleared by any exit from PART (and while outside PART).
      assign part_hold = (state_reg == S_PART) && (state_next == S_PART);

      always_comb begin
        stall_cnt_next = '0;
        if (part_hold) begin
          stall_cnt_next = (stall_cnt_reg == STALL_MAX) ? stall_cnt_reg
                                                        : stall_cnt_reg + STALL_ONE;
        end
      end

      // The flag sets on the edge the count reaches the limit. Because the
      // counter saturates above the limit, this happens once per PART
      // episode, so a clear issued later in the same episode sticks. A set
      // and a clear on the same edge resolve to set.
      assign stall_hit  = part_hold &&
                          (({1'b0, stall_cnt_reg} + STALL_ONE_W) == STALL_LIM_W);
      assign stall_next = stall_hit | (stall_reg & ~bus.stall_clr_i);

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg     <= S_IDLE;
          stall_cnt_reg <= '0;
          evt_reg       <= 1'b0;
          pend_reg      <= 1'b0;
          stall_reg     <= 1'b0;
        end else begin
          state_reg     <= state_next;
          stall_cnt_reg <= stall_cnt_next;
          // Outputs are registered copies of the next-state decode, so they
          // are glitch-free and line up exactly with state_reg.
          evt_reg       <= (state_next == S_FIRE);
          pend_reg      <= (state_next == S_PART);
          stall_reg     <= stall_next;
        end
      end

      assign evt_vec[gi]   = evt_reg;
      assign pend_vec[gi]  = pend_reg;
      assign stall_vec[gi] = stall_reg;

    end
  endgenerate

  assign bus.evt_o   = evt_vec;
  assign bus.pend_o  = pend_vec;
  assign bus.stall_o = stall_vec;

`ifdef EVT_COUNT_EN

  // One saturating counter per event, stepped on every FIRE cycle (the
  // cycle evt_o is high).
  logic [15:0] fire_cnt_reg [N_EVT];
  logic [15:0] cnt_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_EVT; i++) begin
        fire_cnt_reg[i] <= 16'h0;
      end
    end else begin
      for (int i = 0; i < N_EVT; i++) begin
        if (evt_vec[i] && (fire_cnt_reg[i] != 16'hFFFF)) begin
          fire_cnt_reg[i] <= fire_cnt_reg[i] + 16'd1;
        end
      end
    end
  end

  // Compare-and-select read: an index with no matching event falls through
  // to zero without ever indexing past the array.
  always_comb begin
    cnt_rd = 16'h0;
    for (int i = 0; i < N_EVT; i++) begin
      if (bus.cnt_sel_i == 6'(i)) begin
        cnt_rd = fire_cnt_reg[i];
      end
    end
  end

  assign bus.cnt_o = cnt_rd;

`else

  // Counters are not built; the select input is kept on the port but has no
  // effect.
  logic cnt_sel_unused;
  assign cnt_sel_unused = ^bus.cnt_sel_i;
  assign bus.cnt_o      = 16'h0;

`endif

endmodule

// File: tb/tb_msfsm_event_join.sv
// -----------------------------------------------------------------------------
// tb_msfsm_event_join
//
// Bench for msfsm_event_join with N_FSM=2, N_EVT=9, STALL_LIMIT=10 and an
// ownership map where event 6 has no owner and event 7 is owned by FSM0 only;
// every other event is owned by both FSMs.
//   1. reset state
//   2. table of single-cycle vectors with expected evt_o / pend_o
//   3. hand-written sequences: stall set/clear, set-vs-clear priority,
//      reset during a handshake, fire counter readout
//   4. random enables checked every cycle against a handshake-level model
// -----------------------------------------------------------------------------
module tb_msfsm_event_join;

  localparam int          NF    = 2;
  localparam int          NE    = 9;
  localparam int          LIMIT = 10;
  localparam logic [17:0] OWN   = 18'h27FBF;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  msfsm_event_join_if #(.N_FSM(NF), .N_EVT(NE)) bus ();

  msfsm_event_join #(
    .N_FSM      (NF),
    .N_EVT      (NE),
    .OWN_MASK   (OWN),
    .STALL_W    (8),
    .STALL_LIMIT(LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] own_mask;
  initial own_mask = OWN;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks each event as "locked" (fired and not yet fully
  // released) plus a run length of consecutive partial cycles.
  // ---------------------------------------------------------------------------
  function automatic bit all_of(input logic [17:0] en, input logic [17:0] m, input int e);
    bit has = 1'b0;
    bit a   = 1'b1;
    for (int f = 0; f < NF; f++) begin
      if (m[f*NE+e]) begin
        has = 1'b1;
        if (!en[f*NE+e]) a = 1'b0;
      end
    end
    return has && a;
  endfunction

  function automatic bit any_of(input logic [17:0] en, input logic [17:0] m, input int e);
    bit y = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (m[f*NE+e] && en[f*NE+e]) y = 1'b1;
    end
    return y;
  endfunction

  logic [8:0] m_locked = '0;
  logic [8:0] m_evt    = '0;
  logic [8:0] m_pend   = '0;
  logic [8:0] m_stall  = '0;
  int         m_run [NE];
  int         m_cnt [NE];

  always @(posedge clk) begin
    for (int e = 0; e < NE; e++) begin
      if (reset) begin
        m_locked[e] <= 1'b0;
        m_evt[e]    <= 1'b0;
        m_pend[e]   <= 1'b0;
        m_stall[e]  <= 1'b0;
        m_run[e]    <= 0;
        m_cnt[e]    <= 0;
      end else begin
        m_locked[e] <= m_locked[e] ? any_of(bus.en_i, own_mask, e)
                                   : all_of(bus.en_i, own_mask, e);
        m_evt[e]    <= !m_locked[e] && all_of(bus.en_i, own_mask, e);
        m_pend[e]   <= !m_locked[e] && any_of(bus.en_i, own_mask, e)
                       && !all_of(bus.en_i, own_mask, e);
        if (m_pend[e] && !m_locked[e] && any_of(bus.en_i, own_mask, e)
            && !all_of(bus.en_i, own_mask, e)) begin
          m_run[e] <= (m_run[e] < 255) ? m_run[e] + 1 : 255;
          if (m_run[e] + 1 == LIMIT)  m_stall[e] <= 1'b1;
          else if (bus.stall_clr_i)   m_stall[e] <= 1'b0;
        end else begin
          m_run[e] <= 0;
          if (bus.stall_clr_i) m_stall[e] <= 1'b0;
        end
        if (m_evt[e] && m_cnt[e] < 65535) m_cnt[e] <= m_cnt[e] + 1;
      end
    end
  end

  function automatic logic [15:0] exp_cnt(input logic [5:0] sel);
`ifdef EVT_COUNT_EN
    if (sel < NE) return 16'(m_cnt[sel]);
    return 16'h0;
`else
    return (sel == 6'd63) ? 16'h0 : 16'h0;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [17:0] en;
    logic [8:0]  evt;
    logic [8:0]  pend;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [17:0] en_r;
    int          slow;

    // event 3: FSM0 = bit 3, FSM1 = bit 12
    tbl[0]  = '{18'h00008, 9'h000, 9'h008};  // FSM0 raises
    tbl[1]  = '{18'h00008, 9'h000, 9'h008};
    tbl[2]  = '{18'h00008, 9'h000, 9'h008};
    tbl[3]  = '{18'h00008, 9'h000, 9'h008};
    tbl[4]  = '{18'h01008, 9'h008, 9'h000};  // FSM1 joins -> fire
    tbl[5]  = '{18'h01008, 9'h000, 9'h000};  // held: no refire
    tbl[6]  = '{18'h00000, 9'h000, 9'h000};  // release
    tbl[7]  = '{18'h01008, 9'h008, 9'h000};  // both at once -> fire
    tbl[8]  = '{18'h00000, 9'h000, 9'h000};
    tbl[9]  = '{18'h22311, 9'h111, 9'h000};  // events 0,4,8 together
    tbl[10] = '{18'h00000, 9'h000, 9'h000};
    tbl[11] = '{18'h00080, 9'h080, 9'h000};  // event 7, single owner
    tbl[12] = '{18'h00080, 9'h000, 9'h000};
    tbl[13] = '{18'h08040, 9'h000, 9'h000};  // event 6 has no owner
    tbl[14] = '{18'h10000, 9'h000, 9'h000};  // non-owner bit for event 7
    tbl[15] = '{18'h01000, 9'h000, 9'h008};  // FSM1 only on event 3
    tbl[16] = '{18'h00000, 9'h000, 9'h000};  // withdrawal, no pulse

    bus.en_i        = '0;
    bus.stall_clr_i = 1'b0;
    bus.cnt_sel_i   = 6'd0;

    // ---- reset state ----
    tick();
    tick();
    chk("reset_evt",   32'(bus.evt_o),   32'h0);
    chk("reset_pend",  32'(bus.pend_o),  32'h0);
    chk("reset_stall", 32'(bus.stall_o), 32'h0);
    chk("reset_cnt",   32'(bus.cnt_o),   32'h0);
    reset = 1'b0;
    tick();

    // ---- table ----
    for (int i = 0; i < 17; i++) begin
      bus.en_i = tbl[i].en;
      tick();
      $display("vec %0d en=%05h evt=%03h pend=%03h", i, tbl[i].en, bus.evt_o, bus.pend_o);
      chk($sformatf("tbl%0d_evt", i),  32'(bus.evt_o),  32'(tbl[i].evt));
      chk($sformatf("tbl%0d_pend", i), 32'(bus.pend_o), 32'(tbl[i].pend));
    end

    // ---- stall on event 2: FSM0 only (bit 2) ----
    bus.en_i = 18'h00004;
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k == 9) begin
        chk("stall_before_limit", 32'(bus.stall_o[2]), 32'h0);
        chk("stall_pend",         32'(bus.pend_o[2]),  32'h1);
      end
    end
    chk("stall_at_limit", 32'(bus.stall_o[2]), 32'h1);
    $display("stall seq: stall=%03h", bus.stall_o);
    bus.en_i = '0;
    tick();
    chk("withdraw_evt",   32'(bus.evt_o),     32'h0);
    chk("withdraw_pend",  32'(bus.pend_o),    32'h0);
    chk("withdraw_stall", 32'(bus.stall_o[2]), 32'h1);
    bus.stall_clr_i = 1'b1;
    tick();
    bus.stall_clr_i = 1'b0;
    chk("stall_cleared", 32'(bus.stall_o), 32'h0);

    // ---- set and clear on the same edge: set wins ----
    bus.en_i = 18'h00004;
    for (int k = 0; k < 10; k++) tick();
    bus.stall_clr_i = 1'b1;
    tick();
    bus.stall_clr_i = 1'b0;
    chk("set_beats_clear", 32'(bus.stall_o[2]), 32'h1);
    bus.en_i = '0;
    tick();

    // ---- reset during PART on event 5 (bits 5, 14) ----
    bus.en_i = 18'h00020;
    tick(); tick(); tick();
    chk("rst_pre_pend", 32'(bus.pend_o[5]), 32'h1);
    bus.en_i = 18'h04020;
    reset = 1'b1;
    tick();
    chk("rst_pend", 32'(bus.pend_o),  32'h0);
    chk("rst_stall", 32'(bus.stall_o), 32'h0);
    tick();
    chk("rst_evt",  32'(bus.evt_o),  32'h0);
    reset = 1'b0;
    tick();
    chk("rst_refire", 32'(bus.evt_o), 32'h020);
    tick();
    chk("rst_once",   32'(bus.evt_o), 32'h000);
    bus.en_i = '0;
    tick();

    // ---- fire counter: three handshakes on event 1 (bits 1, 10) ----
    for (int h = 0; h < 3; h++) begin
      bus.en_i = 18'h00402;
      tick();
      $display("handshake %0d evt=%03h", h, bus.evt_o);
      bus.en_i = '0;
      tick();
    end
    bus.cnt_sel_i = 6'd1;
    #1;
`ifdef EVT_COUNT_EN
    chk("cnt_evt1", 32'(bus.cnt_o), 32'd3);
`else
    chk("cnt_evt1", 32'(bus.cnt_o), 32'd0);
`endif
    bus.cnt_sel_i = 6'd5;
    #1;
`ifdef EVT_COUNT_EN
    chk("cnt_evt5", 32'(bus.cnt_o), 32'd1);
`else
    chk("cnt_evt5", 32'(bus.cnt_o), 32'd0);
`endif
    bus.cnt_sel_i = 6'd12;
    #1;
    chk("cnt_out_of_range", 32'(bus.cnt_o), 32'd0);

    // ---- random phase against the model ----
    en_r = '0;
    slow = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) slow = $urandom_range(0, 1);
      for (int b = 0; b < 18; b++) begin
        if ($urandom_range(0, slow ? 31 : 3) == 0) en_r[b] = ~en_r[b];
      end
      bus.en_i        = en_r;
      bus.stall_clr_i = ($urandom_range(0, 31) == 0);
      bus.cnt_sel_i   = 6'($urandom_range(0, 15));
      reset           = ($urandom_range(0, 499) == 0);
      tick();
      if (bus.evt_o != 9'h0)
        $display("cyc %0d fire evt=%03h pend=%03h stall=%03h", c, bus.evt_o, bus.pend_o, bus.stall_o);
      chk("rnd_evt",   32'(bus.evt_o),   32'(m_evt));
      chk("rnd_pend",  32'(bus.pend_o),  32'(m_pend));
      chk("rnd_stall", 32'(bus.stall_o), 32'(m_stall));
      chk("rnd_cnt",   32'(bus.cnt_o),   32'(exp_cnt(bus.cnt_sel_i)));
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
